// File: rtl/vga_pixel_fetch_if.sv
// RAM read port between the pixel fetcher (master) and the shared data RAM (slave).
interface vga_pixel_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_addr, input  mem_gnt, mem_rdata);
  modport slave  (input  mem_req, mem_addr, output mem_gnt, mem_rdata);
endinterface

// File: rtl/vga_pixel_fetch.sv
// Fetches 2-bpp framebuffer lines into a ping-pong line buffer and emits scaled RGB with matched sync/blank.
// Optional PALETTE_WR_EN adds a writable 4-entry palette (pal_we/pal_idx/pal_data).
module vga_pixel_fetch #(
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter int          SCALE    = 4,
  parameter logic [31:0] FB_BASE  = 32'h0000_0400
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              active,
  input  logic              hsync_in,
  input  logic              vsync_in,
  vga_pixel_fetch_if.master mem,
`ifdef PALETTE_WR_EN
  input  logic              pal_we,
  input  logic [1:0]        pal_idx,
  input  logic [23:0]       pal_data,
`endif
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_b_out,
  output logic              underrun
);
  localparam int WPL = (H_ACTIVE/SCALE)*2/32;
  localparam int IW  = (WPL > 1) ? $clog2(WPL) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } ctl_t;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [9:0]    src_row;
  logic          fetch_done, front, vs_prev;
  logic [31:0]   lbuf [2][WPL];

  logic [31:0]   xi, yi, pw, wsel;
  logic          frame_trig, line_trig, trig, swap_pt, do_toggle, front_rd;
  logic [9:0]    trig_row;
  logic [31:0]   rd_word;
  logic [4:0]    rd_shift;

  ctl_t          s1_ctl;
  logic [31:0]   s1_word;
  logic [4:0]    s1_shift;
  logic [1:0]    code;
  logic [23:0]   pal_rgb;

  always_comb begin
    xi         = {22'd0, x};
    yi         = {22'd0, y};
    frame_trig = pix_en && vsync_in && !vs_prev;
    line_trig  = pix_en && (xi == H_ACTIVE) && (yi < V_ACTIVE-1) && ((yi + 1) % SCALE == 0);
    trig       = frame_trig || line_trig;
    trig_row   = frame_trig ? 10'd0 : 10'((yi + 1) / SCALE);
    swap_pt    = pix_en && active && (xi == 0) && (yi % SCALE == 0);
    do_toggle  = swap_pt && fetch_done;
    // The swap strobe's own pixel must already come from the newly swapped-in line.
    front_rd   = front ^ do_toggle;
    pw         = xi / SCALE;
    wsel       = pw / 16;
    rd_shift   = 5'((pw % 16) * 2);
    rd_word    = '0;
    if (wsel < WPL) rd_word = lbuf[front_rd][wsel[IW-1:0]];
  end

  assign mem.mem_req  = (state == S_REQ);
  assign mem.mem_addr = FB_BASE + (32'(src_row) * 32'(WPL) + 32'(idx)) * 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      src_row    <= '0;
      fetch_done <= 1'b0;
      front      <= 1'b0;
      vs_prev    <= 1'b1;
      underrun   <= 1'b0;
    end else begin
      if (pix_en) vs_prev <= vsync_in;
      case (state)
        S_IDLE: if (trig) begin
          state      <= S_REQ;
          src_row    <= trig_row;
          idx        <= '0;
          fetch_done <= 1'b0;
        end
        S_REQ:  if (mem.mem_gnt) state <= S_WAIT;
        S_WAIT: if (idx == IW'(WPL-1)) state <= S_DONE;
                else begin
                  idx   <= idx + 1'b1;
                  state <= S_REQ;
                end
        default: begin
          fetch_done <= 1'b1;
          state      <= S_IDLE;
        end
      endcase
      if (trig && state != S_IDLE) underrun <= 1'b1;
      if (swap_pt) begin
        if (fetch_done) begin
          front      <= ~front;
          fetch_done <= 1'b0;
        end else begin
          underrun   <= 1'b1;
        end
      end
    end
  end

  // Line buffer is deliberately not reset; a beat arriving during reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && state == S_WAIT) lbuf[~front][idx] <= mem.mem_rdata;
  end

  assign code = s1_word[s1_shift +: 2];

`ifdef PALETTE_WR_EN
  logic [3:0][23:0] pal_q;
  always_ff @(posedge clk) begin
    if (reset)       pal_q <= {24'hFFFFFF, 24'h00FF00, 24'hFF0000, 24'h000000};
    else if (pal_we) pal_q[pal_idx] <= pal_data;
  end
  assign pal_rgb = pal_q[code];
`else
  always_comb begin
    case (code)
      2'd0:    pal_rgb = 24'h000000;
      2'd1:    pal_rgb = 24'hFF0000;
      2'd2:    pal_rgb = 24'h00FF00;
      default: pal_rgb = 24'hFFFFFF;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_ctl      <= '{hs: 1'b1, vs: 1'b1, act: 1'b0};
      s1_word     <= '0;
      s1_shift    <= '0;
      {r, g, b}   <= 24'h0;
      hsync_out   <= 1'b1;
      vsync_out   <= 1'b1;
      blank_b_out <= 1'b0;
    end else if (pix_en) begin
      s1_ctl      <= '{hs: hsync_in, vs: vsync_in, act: active};
      s1_word     <= rd_word;
      s1_shift    <= rd_shift;
      {r, g, b}   <= s1_ctl.act ? pal_rgb : 24'h0;
      hsync_out   <= s1_ctl.hs;
      vsync_out   <= s1_ctl.vs;
      blank_b_out <= s1_ctl.act;
    end
  end
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Randomized scoreboard bench for vga_pixel_fetch: RAM slave, fetch/swap reference model, pixel and request monitors.
module tb_vga_pixel_fetch;
  localparam int HTOT = 700;
  typedef logic [26:0] pix_t;  // {rgb, hsync, vsync, blank_b}

  logic       clk = 1'b0;
  logic       reset, pix_en, active, hsync_in, vsync_in;
  logic [9:0] x, y;
  logic [7:0] r, g, b;
  logic       hsync_out, vsync_out, blank_b_out, underrun;
`ifdef PALETTE_WR_EN
  logic        pal_we = 1'b0;
  logic [1:0]  pal_idx = 2'd0;
  logic [23:0] pal_data = 24'd0;
`endif

  vga_pixel_fetch_if bus ();

  vga_pixel_fetch dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .x(x), .y(y), .active(active),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .mem(bus),
`ifdef PALETTE_WR_EN
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
`endif
    .r(r), .g(g), .b(b), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .blank_b_out(blank_b_out), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_err = 0;
  logic [31:0] fbm [1200];
  logic [31:0] aq [$];
  pix_t        pq [$];
  int          gnt_mode = 0;  // 0 = held low, 1 = tied high, 2 = random
  int          served_total = 0, m_target = 0, m_disp = 0, m_pend = 0;
  bit          m_consumed = 1'b1, m_vs_prev = 1'b1, m_underrun = 1'b0;
  longint      cyc = 0, last_gnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic logic [23:0] pal(input logic [1:0] c);
    case (c)
      2'd0:    return 24'h000000;
      2'd1:    return 24'hFF0000;
      2'd2:    return 24'h00FF00;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  // Source pixel (x/4) of the displayed source row, 16 pixels per word, LSB first.
  function automatic pix_t exp_pix(input int xx, input bit act, input bit hs, input bit vs);
    logic [31:0] w;
    int p;
    if (!act) return {24'h0, hs, vs, 1'b0};
    p = xx / 4;
    w = fbm[m_disp*10 + p/16];
    return {pal(w[2*(p%16) +: 2]), hs, vs, 1'b1};
  endfunction

  task automatic issue(input int row);
    for (int i = 0; i < 10; i++) aq.push_back(32'h400 + 32'((row*10 + i) * 4));
    m_target  += 10;
    m_consumed = 1'b0;
    m_pend     = row;
  endtask

  task automatic strobe(input int xx, input int yy, input bit act, input bit hs, input bit vs);
    @(negedge clk);
    pix_en = 1'b1; x = 10'(xx); y = 10'(yy); active = act; hsync_in = hs; vsync_in = vs;
    if (vs && !m_vs_prev) issue(0);
    m_vs_prev = vs;
    if (xx == 640 && yy < 479 && (yy+1) % 4 == 0) issue((yy+1) / 4);
    if (act && xx == 0 && yy % 4 == 0) begin
      if (!m_consumed && served_total >= m_target) begin
        m_disp     = m_pend;
        m_consumed = 1'b1;
      end else m_underrun = 1'b1;
    end
    pq.push_back(exp_pix(xx, act, hs, vs));
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  task automatic line(input int yy, input int rel_x);
    for (int xx = 0; xx < HTOT; xx++) begin
      if (xx == rel_x) gnt_mode = 2;
      strobe(xx, yy, xx < 640, !(xx >= 660 && xx < 680), 1'b1);
    end
    chk($sformatf("underrun_y%0d", yy), 32'(underrun), 32'(m_underrun));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; pix_en = 1'b0;
    @(negedge clk);
    chk("rst_mem_req",  32'(bus.mem_req), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_rgb",      {8'd0, r, g, b}, 32'd0);
    chk("rst_sync",     {29'd0, hsync_out, vsync_out, blank_b_out}, 32'b110);
    aq.delete(); pq.delete();
    pq.push_back({24'h0, 1'b1, 1'b1, 1'b0});
    m_target = 0; m_consumed = 1'b1; m_underrun = 1'b0; m_vs_prev = 1'b1;
    reset = 1'b0;
  endtask

  // Grant driver
  initial forever begin
    @(negedge clk);
    bus.mem_gnt = (gnt_mode == 1) ? 1'b1 : (gnt_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b0;
  end

  // RAM slave and request monitor
  initial forever begin
    logic [31:0] a;
    @(posedge clk);
    cyc = cyc + 1;
    a = bus.mem_addr;
    if (bus.mem_req && bus.mem_gnt && a >= 32'h400 && a < 32'h400 + 32'd4800)
      bus.mem_rdata <= fbm[(a - 32'h400) / 4];
    else
      bus.mem_rdata <= $urandom;
    if (reset) served_total = 0;
    else if (bus.mem_req && bus.mem_gnt) begin
      if (aq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_req: addr %h, required no request", a);
      end else chk("req_addr", a, aq.pop_front());
      if (gnt_mode == 1 && served_total % 10 != 0) chk("gnt_spacing", 32'(cyc - last_gnt), 32'd2);
      last_gnt = cyc;
      served_total = served_total + 1;
    end
  end

  // Pixel monitor: outputs after strobe k reflect the inputs of strobe k-1.
  initial forever begin
    pix_t e;
    @(posedge clk);
    if (pix_en && !reset) begin
      #1;
      if (pq.size() >= 2) begin
        e = pq.pop_front();
        chk("pix_rgb",  {8'd0, r, g, b}, {8'd0, e[26:3]});
        chk("pix_ctrl", {29'd0, hsync_out, vsync_out, blank_b_out}, {29'd0, e[2:0]});
      end
    end
  end

  initial begin
    bit found;
    reset = 1'b1; pix_en = 1'b0; x = '0; y = '0; active = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    bus.mem_gnt = 1'b0; bus.mem_rdata = '0;
    for (int i = 0; i < 1200; i++) fbm[i] = $urandom;
    fbm[0] = 32'h0000_00E4;
    do_reset();

    // Frame fetch with grant tied high, then display with random grant latency
    gnt_mode = 1;
    strobe(0, 480, 1'b0, 1'b1, 1'b1);
    strobe(1, 480, 1'b0, 1'b1, 1'b0);
    strobe(2, 480, 1'b0, 1'b1, 1'b0);
    for (int i = 3; i < 27; i++) strobe(i, 480, 1'b0, 1'b1, 1'b1);
    gnt_mode = 2;
    for (int yy = 0; yy < 7; yy++) line(yy, -1);
    // Starve the row-2 fetch across the y=8 swap point
    gnt_mode = 0;
    line(7, -1);
    line(8, 200);
    for (int yy = 9; yy < 16; yy++) line(yy, -1);
    for (int i = 0; i < 40; i++) strobe(i, 16, 1'b0, 1'b1, 1'b1);
    chk("addr_q_drained", 32'(aq.size()), 32'd0);
    chk("underrun_sticky", 32'(underrun), 32'd1);

    // Reset while a beat is outstanding
    strobe(0, 480, 1'b0, 1'b1, 1'b0);
    strobe(1, 480, 1'b0, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      if (bus.mem_req && bus.mem_gnt) found = 1'b1;
    end
    if (!found) begin
      n_cmp++; n_err++;
      $display("FAIL mid_fetch_wait: no grant within 200 cycles, required one");
    end
    do_reset();

    // No requests without a trigger, then a clean refetch of row 0
    gnt_mode = 1;
    for (int i = 0; i < 12; i++) strobe(i, 481, 1'b0, 1'b1, 1'b1);
    strobe(12, 481, 1'b0, 1'b1, 1'b0);
    strobe(13, 481, 1'b0, 1'b1, 1'b1);
    for (int i = 14; i < 40; i++) strobe(i, 481, 1'b0, 1'b1, 1'b1);
    chk("refetch_drained", 32'(aq.size()), 32'd0);
    chk("refetch_underrun", 32'(underrun), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
